// File: rtl/wdata_chan_rcvr_if.sv
// Bus-side W/B channels plus memory write port of the write-data receiver.
// slave = receiver view; master = the bus/memory driver view.
interface wdata_chan_rcvr_if #(
    parameter int ID_WIDTH = 4
);
    logic                aw_rq;
    logic [ID_WIDTH-1:0] aw_id;
    logic                aw_busy;
    logic                wvalid;
    logic                wready;
    logic [31:0]         wdata;
    logic                wlast;
    logic                wr_rq;
    logic [ID_WIDTH-1:0] wr_id;
    logic [127:0]        wr_data;
    logic                wr_ack;
    logic                bvalid;
    logic                bready;
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;

    modport slave (
        input  aw_rq, aw_id, wvalid, wdata, wlast, wr_ack, bready,
        output aw_busy, wready, wr_rq, wr_id, wr_data, bvalid, bid, bresp
    );

    modport master (
        output aw_rq, aw_id, wvalid, wdata, wlast, wr_ack, bready,
        input  aw_busy, wready, wr_rq, wr_id, wr_data, bvalid, bid, bresp
    );
endinterface

// File: rtl/wdata_chan_rcvr.sv
// Collects a 4-beat 32-bit W burst into 128 bits, writes it to memory (req/ack), then answers on B.
// Best case aw_rq->wr_rq 5 cycles; W stalls on wvalid, memory on wr_ack, response on bready, no timeouts.
module wdata_chan_rcvr #(
    parameter int ID_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    wdata_chan_rcvr_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        MWRT = 2'd2,
        BRSP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic                err_q, err_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [127:0]        data_q, data_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                beat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            err_q   <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
            bresp_q <= 2'b00;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            id_q    <= id_d;
            data_q  <= data_d;
            bresp_q <= bresp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        err_d    = err_q;
        id_d     = id_q;
        data_d   = data_q;
        bresp_d  = bresp_q;
        beat_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.aw_rq) begin
                    id_d    = bus.aw_id;
                    beat_d  = 2'd0;
                    err_d   = 1'b0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.wvalid) begin
                    data_d[{beat_q, 5'd0} +: 32] = bus.wdata;
                    beat_d   = beat_q + 2'd1;
                    // wlast must be set on the final beat and only there; length stays 4 either way
                    beat_err = (beat_q == 2'd3) ? ~bus.wlast : bus.wlast;
                    err_d    = err_q | beat_err;
                    if (beat_q == 2'd3) begin
                        if (err_d) begin
                            bresp_d = 2'b10;
                            state_d = BRSP;
                        end else begin
                            state_d = MWRT;
                        end
                    end
                end
            end
            MWRT: begin
                if (bus.wr_ack) begin
                    bresp_d = 2'b00;
                    state_d = BRSP;
                end
            end
            BRSP: begin
                if (bus.bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.aw_busy = (state_q != IDLE);
    assign bus.wready  = (state_q == RECV);
    assign bus.wr_rq   = (state_q == MWRT);
    assign bus.bvalid  = (state_q == BRSP);
    assign bus.wr_id   = id_q;
    assign bus.bid     = id_q;
    assign bus.wr_data = data_q;
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_wdata_chan_rcvr.sv
// Directed bench for wdata_chan_rcvr: transaction-level model compared every cycle plus literal expectations.
module tb_wdata_chan_rcvr;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wdata_chan_rcvr_if #(.ID_WIDTH(IDW)) bus();
    wdata_chan_rcvr #(.ID_WIDTH(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vecs = 0;
    int errs = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Transaction model: is a write open, how many beats seen, was wlast misplaced,
    // is the memory write or the response outstanding.
    bit              m_busy, m_bad, m_wr, m_rsp;
    int              m_n;
    logic [1:0]      m_code;
    logic [IDW-1:0]  m_id;
    logic [31:0]     m_lane [4];

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_bad = 0; m_wr = 0; m_rsp = 0; m_n = 0;
            m_code = 2'b00; m_id = '0;
            for (int i = 0; i < 4; i++) m_lane[i] = 32'h0;
        end else if (!m_busy) begin
            if (bus.aw_rq) begin
                m_busy = 1; m_n = 0; m_bad = 0; m_id = bus.aw_id;
            end
        end else if (m_rsp) begin
            if (bus.bready) begin
                m_rsp = 0; m_busy = 0;
            end
        end else if (m_wr) begin
            if (bus.wr_ack) begin
                m_wr = 0; m_rsp = 1; m_code = 2'b00;
            end
        end else if (bus.wvalid) begin
            m_lane[m_n] = bus.wdata;
            if (bus.wlast != (m_n == 3)) m_bad = 1;
            m_n++;
            if (m_n == 4) begin
                if (m_bad) begin
                    m_rsp = 1; m_code = 2'b10;
                end else begin
                    m_wr = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("aw_busy", bus.aw_busy, m_busy);
            chk("wready", bus.wready, m_busy && !m_wr && !m_rsp);
            chk("wr_rq", bus.wr_rq, m_wr);
            chk("bvalid", bus.bvalid, m_rsp);
            chk("wr_data", bus.wr_data, {m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
            if (m_wr) chk("wr_id", bus.wr_id, m_id);
            if (m_rsp) begin
                chk("bid", bus.bid, m_id);
                chk("bresp", bus.bresp, m_code);
            end
        end
    end

    // All tasks start and end just after a falling edge.
    task automatic aw(input logic [IDW-1:0] id);
        bus.aw_rq = 1'b1;
        bus.aw_id = id;
        @(negedge clk);
        bus.aw_rq = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        int i = 0;
        bus.wvalid = 1'b1;
        bus.wdata  = d;
        bus.wlast  = last;
        while (!bus.wready && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!bus.wready) begin
            vecs++; errs++;
            $display("FAIL beat_timeout: wready=0 after %0d cycles, required 1", i);
        end else begin
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic do_ack(input int dly);
        int i = 0;
        while (!bus.wr_rq && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!bus.wr_rq) begin
            vecs++; errs++;
            $display("FAIL wr_rq_timeout: wr_rq=0 after %0d cycles, required 1", i);
        end else begin
            repeat (dly) @(negedge clk);
            bus.wr_ack = 1'b1;
            @(negedge clk);
            bus.wr_ack = 1'b0;
        end
    endtask

    task automatic do_resp(input int dly, input logic [IDW-1:0] exp_id, input logic [1:0] exp_code,
                           input bit aw_too, input logic [IDW-1:0] aw_id2);
        int i = 0;
        while (!bus.bvalid && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!bus.bvalid) begin
            vecs++; errs++;
            $display("FAIL bvalid_timeout: bvalid=0 after %0d cycles, required 1", i);
        end else begin
            chk("lit_bid", bus.bid, exp_id);
            chk("lit_bresp", bus.bresp, exp_code);
            repeat (dly) @(negedge clk);
            bus.bready = 1'b1;
            if (aw_too) begin
                bus.aw_rq = 1'b1;
                bus.aw_id = aw_id2;
            end
            @(negedge clk);
            bus.bready = 1'b0;
            bus.aw_rq  = 1'b0;
        end
    endtask

    initial begin
        bus.aw_rq = 0; bus.aw_id = '0; bus.wvalid = 0; bus.wdata = '0;
        bus.wlast = 0; bus.wr_ack = 0; bus.bready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_aw_busy", bus.aw_busy, 1'b0);
        chk("rst_wr_data", bus.wr_data, 128'h0);
        chk("rst_bid", bus.bid, 4'h0);
        chk("rst_bresp", bus.bresp, 2'b00);
        @(negedge clk);

        // basic burst, best-case latency
        aw(4'h5);
        chk("lat_wready", bus.wready, 1'b1);
        beat(32'h11111111, 0);
        beat(32'h22222222, 0);
        beat(32'h33333333, 0);
        beat(32'h44444444, 1);
        chk("lat_wr_rq", bus.wr_rq, 1'b1);
        chk("lit_wr_data", bus.wr_data, 128'h44444444_33333333_22222222_11111111);
        chk("lit_wr_id", bus.wr_id, 4'h5);
        do_ack(0);
        chk("lat_bvalid", bus.bvalid, 1'b1);
        do_resp(0, 4'h5, 2'b00, 0, 4'h0);
        chk("lat_aw_busy", bus.aw_busy, 1'b0);
        @(negedge clk);

        // stalls everywhere
        aw(4'hC);
        beat(32'hA0A0A0A0, 0);
        beat(32'hB1B1B1B1, 0);
        repeat (3) @(negedge clk);
        beat(32'hC2C2C2C2, 0);
        beat(32'hD3D3D3D3, 1);
        do_ack(4);
        chk("lit_stall_data", bus.wr_data, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
        do_resp(2, 4'hC, 2'b00, 0, 4'h0);
        repeat (3) @(negedge clk);

        // misplaced wlast
        aw(4'hA);
        beat(32'h01010101, 0);
        beat(32'h02020202, 1);
        beat(32'h03030303, 0);
        beat(32'h04040404, 0);
        chk("lit_err_no_wr", bus.wr_rq, 1'b0);
        do_resp(1, 4'hA, 2'b10, 0, 4'h0);
        @(negedge clk);

        // aw_rq while busy and during the B handshake are both ignored
        aw(4'h7);
        aw(4'h3);
        beat(32'hDEADBEEF, 0);
        beat(32'hCAFEF00D, 0);
        beat(32'h12345678, 0);
        beat(32'h9ABCDEF0, 1);
        do_ack(1);
        do_resp(0, 4'h7, 2'b00, 1, 4'h3);
        chk("lit_b2b_idle", bus.aw_busy, 1'b0);
        aw(4'h3);
        beat(32'h55555555, 0);
        beat(32'h66666666, 0);
        beat(32'h77777777, 0);
        beat(32'h88888888, 1);
        do_ack(0);
        do_resp(0, 4'h3, 2'b00, 0, 4'h0);
        @(negedge clk);

        // reset mid-burst
        aw(4'h9);
        beat(32'hFFFF0000, 0);
        beat(32'h0000FFFF, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_wready", bus.wready, 1'b0);
        chk("mrst_aw_busy", bus.aw_busy, 1'b0);
        chk("mrst_wr_data", bus.wr_data, 128'h0);
        aw(4'h2);
        beat(32'h00000001, 0);
        beat(32'h00000002, 0);
        beat(32'h00000003, 0);
        beat(32'h00000004, 1);
        chk("lit_post_rst_data", bus.wr_data, 128'h00000004_00000003_00000002_00000001);
        do_ack(0);
        do_resp(0, 4'h2, 2'b00, 0, 4'h0);

        // W traffic in IDLE is never accepted
        bus.wvalid = 1'b1;
        bus.wdata  = 32'hBAD0BAD0;
        bus.wlast  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_wready", bus.wready, 1'b0);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_wr_rq", bus.wr_rq, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
